// File: rtl/ej32_stack_au.sv
// rtl/ej32_stack_au.sv - eJ32 data stack with single-cycle ALU and iterative signed divider
// Divider compiled only when EJ32_AU_DIV_EN is defined.
module ej32_stack_au #(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_vld,
  output logic                   op_rdy,
  input  logic [4:0]             op,
  input  logic [DW-1:0]          imm,
  output logic [DW-1:0]          tos,
  output logic [DW-1:0]          nos,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   busy,
  output logic                   ovf,
  output logic                   unf,
  output logic                   dz
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DW);

  localparam logic [4:0] OP_PUSH = 5'd1,  OP_POP  = 5'd2,  OP_DUP  = 5'd3,  OP_SWAP = 5'd4;
  localparam logic [4:0] OP_OVER = 5'd5,  OP_ADD  = 5'd6,  OP_SUB  = 5'd7,  OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9,  OP_XOR  = 5'd10, OP_SHL  = 5'd11, OP_SHR  = 5'd12;
  localparam logic [4:0] OP_USHR = 5'd13, OP_DIV  = 5'd14, OP_REM  = 5'd15, OP_CLRF = 5'd16;
  localparam logic [4:0] OP_CLRS = 5'd17;

  logic [DW-1:0] tos_r, nos_r;
  logic [AW:0]   depth_r;
  logic [DW-1:0] store [DEPTH];
  logic          ovf_r, unf_r;

  logic          accept;
  logic [AW:0]   need;
  logic          push_t, bin_t, is_div;
  logic          err_unf, err_ovf, do_op;
  logic [DW-1:0] alu, refill;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          div_wb;
  logic [DW-1:0] div_res;

  assign op_rdy  = !busy;
  assign accept  = op_vld & op_rdy;
  // Entries below NOS live in store[0 .. depth-3]; the top of that region is rd_idx.
  assign rd_idx  = depth_r[AW-1:0] - AW'(3);
  assign wr_idx  = depth_r[AW-1:0] - AW'(2);
  assign refill  = (depth_r >= (AW+1)'(3)) ? store[rd_idx] : '0;

  always_comb begin
    need   = '0;
    push_t = 1'b0;
    bin_t  = 1'b0;
    is_div = 1'b0;
    alu    = '0;
    case (op)
      OP_PUSH: push_t = 1'b1;
      OP_POP:  need = (AW+1)'(1);
      OP_DUP:  begin need = (AW+1)'(1); push_t = 1'b1; end
      OP_SWAP: need = (AW+1)'(2);
      OP_OVER: begin need = (AW+1)'(2); push_t = 1'b1; end
      OP_ADD:  begin need = (AW+1)'(2); bin_t = 1'b1; alu = nos_r + tos_r; end
      OP_SUB:  begin need = (AW+1)'(2); bin_t = 1'b1; alu = nos_r - tos_r; end
      OP_AND:  begin need = (AW+1)'(2); bin_t = 1'b1; alu = nos_r & tos_r; end
      OP_OR:   begin need = (AW+1)'(2); bin_t = 1'b1; alu = nos_r | tos_r; end
      OP_XOR:  begin need = (AW+1)'(2); bin_t = 1'b1; alu = nos_r ^ tos_r; end
      OP_SHL:  begin need = (AW+1)'(2); bin_t = 1'b1; alu = nos_r << tos_r[SW-1:0]; end
      OP_SHR:  begin need = (AW+1)'(2); bin_t = 1'b1; alu = $unsigned($signed(nos_r) >>> tos_r[SW-1:0]); end
      OP_USHR: begin need = (AW+1)'(2); bin_t = 1'b1; alu = nos_r >> tos_r[SW-1:0]; end
`ifdef EJ32_AU_DIV_EN
      OP_DIV, OP_REM: begin need = (AW+1)'(2); is_div = 1'b1; end
`endif
      default: ;
    endcase
    err_unf = depth_r < need;
    err_ovf = push_t && !err_unf && (depth_r == (AW+1)'(DEPTH));
    do_op   = accept && !err_unf && !err_ovf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_r   <= '0;
      nos_r   <= '0;
      depth_r <= '0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      if (div_wb) begin
        tos_r   <= div_res;
        nos_r   <= refill;
        depth_r <= depth_r - (AW+1)'(1);
      end else if (do_op) begin
        if (bin_t) begin
          tos_r   <= alu;
          nos_r   <= refill;
          depth_r <= depth_r - (AW+1)'(1);
        end else begin
          case (op)
            OP_PUSH: begin tos_r <= imm;   nos_r <= tos_r; depth_r <= depth_r + (AW+1)'(1); end
            OP_DUP:  begin                 nos_r <= tos_r; depth_r <= depth_r + (AW+1)'(1); end
            OP_OVER: begin tos_r <= nos_r; nos_r <= tos_r; depth_r <= depth_r + (AW+1)'(1); end
            OP_POP:  begin tos_r <= nos_r; nos_r <= refill; depth_r <= depth_r - (AW+1)'(1); end
            OP_SWAP: begin tos_r <= nos_r; nos_r <= tos_r; end
            OP_CLRS: depth_r <= '0;
            default: ;
          endcase
        end
      end
      if (accept) begin
        if (op == OP_CLRF) begin
          ovf_r <= 1'b0;
          unf_r <= 1'b0;
        end else begin
          if (err_unf) unf_r <= 1'b1;
          if (err_ovf) ovf_r <= 1'b1;
        end
      end
    end
  end

  // A push-type op moves the old NOS into the store only when it held a real entry.
  always_ff @(posedge clk) begin
    if (do_op && push_t && depth_r >= (AW+1)'(2))
      store[wr_idx] <= nos_r;
  end

  assign tos   = (depth_r != '0) ? tos_r : '0;
  assign nos   = (depth_r >= (AW+1)'(2)) ? nos_r : '0;
  assign depth = depth_r;
  assign ovf   = ovf_r;
  assign unf   = unf_r;

`ifdef EJ32_AU_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} div_state_t;
  div_state_t    state, state_nxt;
  logic [DW-1:0] quo, rem, dvs, dvd, rem_sh, rem_nx, quo_nx;
  logic [SW:0]   cnt;
  logic          q_neg, r_neg, is_rem, dz_pend, dz_r, ge, div_start;

  assign div_start = accept && is_div && !err_unf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (div_start) state_nxt = (tos_r == '0) ? S_FIX : S_RUN;
      S_RUN:   if (cnt == (SW+1)'(DW-1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One restoring step; the partial remainder never exceeds DW bits since |divisor| <= 2^(DW-1).
  always_comb begin
    rem_sh = {rem[DW-2:0], quo[DW-1]};
    ge     = rem_sh >= dvs;
    rem_nx = ge ? rem_sh - dvs : rem_sh;
    quo_nx = {quo[DW-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo <= '0; rem <= '0; dvs <= '0; dvd <= '0; cnt <= '0;
      q_neg <= 1'b0; r_neg <= 1'b0; is_rem <= 1'b0; dz_pend <= 1'b0; dz_r <= 1'b0;
    end else begin
      if (state == S_IDLE && div_start) begin
        quo     <= nos_r[DW-1] ? -nos_r : nos_r;
        dvs     <= tos_r[DW-1] ? -tos_r : tos_r;
        rem     <= '0;
        dvd     <= nos_r;
        cnt     <= '0;
        q_neg   <= nos_r[DW-1] ^ tos_r[DW-1];
        r_neg   <= nos_r[DW-1];
        is_rem  <= (op == OP_REM);
        dz_pend <= (tos_r == '0);
      end else if (state == S_RUN) begin
        quo <= quo_nx;
        rem <= rem_nx;
        cnt <= cnt + (SW+1)'(1);
      end else if (state == S_FIX && dz_pend) begin
        dz_r <= 1'b1;
      end
      if (accept && op == OP_CLRF) dz_r <= 1'b0;
    end
  end

  always_comb begin
    if (dz_pend)     div_res = is_rem ? dvd : '1;
    else if (is_rem) div_res = r_neg ? -rem : rem;
    else             div_res = q_neg ? -quo : quo;
  end

  assign div_wb = (state == S_FIX);
  assign busy   = (state != S_IDLE);
  assign dz     = dz_r;
`else
  assign div_wb  = 1'b0;
  assign div_res = '0;
  assign busy    = 1'b0;
  assign dz      = 1'b0;
`endif

endmodule
